instruction_fetcher: RTL and testbench
======================================

// Module: instruction_fetcher
// PURPOSE
//  Owns the PC and drives the instruction cache read address every cycle. On cache hit it pushes
//  {pc, inst} into an internal FIFO instruction queue that the decoder drains.
//  Applies static JAL target prediction; all other control flow is predicted fall-through.
//  Backend redirects (mispredict/jalr) flush the queue and reload the PC.
// PARAMETERS
//  PC_WIDTH    32  byte-address PC width
//  ADDR_WIDTH  17  instruction-cache word-address width (= pc[ADDR_WIDTH+1:2])
//  INST_WIDTH  32  instruction width
//  IQ_LOG      3   log2 of instruction-queue depth (default 8 entries)
//  RESET_PC    0   PC value after reset
// PORTS
//  clk             in   1           clock
//  rst             in   1           reset: synchronous, active-high
//  rdy             in   1           global ready; low = freeze all state
//  icache_addr     out  ADDR_WIDTH  word address to cache = pc[ADDR_WIDTH+1:2], combinational
//  icache_done     in   1           cache hit; icache_data valid for icache_addr this cycle
//  icache_data     in   INST_WIDTH  instruction at icache_addr
//  iq_valid        out  1           queue non-empty; head entry presented
//  iq_inst         out  INST_WIDTH  head instruction
//  iq_pc           out  PC_WIDTH    head PC
//  iq_ready        in   1           decoder accepts head this cycle
//  redirect_valid  in   1           backend flush request
//  redirect_pc     in   PC_WIDTH    new PC; bits [1:0] forced to 0
// BEHAVIOUR
//  Reset: pc=RESET_PC; head=tail=count=0; iq_valid=0; iq_inst=0; iq_pc=0.
//  Queue: circular buffer, head/tail IQ_LOG bits, wrap modulo depth.
//   count is IQ_LOG+1 bits; full when count==2**IQ_LOG.
//   Outputs come from the registered head entry.
//  All updates require rdy=1; rdy=0 holds pc, pointers and count. icache_addr still follows pc.
//  Priority per cycle (rdy=1):
//   1. redirect_valid:
//      - pc<=redirect_pc&~3; head=tail=count<=0.
//      - No push and no pop take effect, even if icache_done or iq_ready are high.
//   2. else pop = iq_valid & iq_ready: head<=head+1.
//   3. else/also push = icache_done & !full:
//      - push uses count before this cycle's pop; full blocks push even if popping.
//      - entry[tail]<={pc,icache_data}; tail<=tail+1.
//      - pc <= next_pc.
//   4. count += push - pop; simultaneous push+pop leaves count unchanged.
//  next_pc:
//   - If icache_data[6:0]==7'b1101111 (JAL): pc + sext({d[31],d[19:12],d[20],d[30:21],1'b0}).
//   - Otherwise pc+4. Arithmetic is modulo 2**PC_WIDTH.
//  Miss (icache_done=0) or full: pc held, no push; icache_addr stays stable.
//  Latency:
//   - A hit in cycle N is visible on iq_* in cycle N+1 if the queue was empty.
//   - The next PC is presented to the cache in N+1.
//  Pushing while the queue is empty and popping in the same cycle is impossible, because iq_valid is low.
//  Reset mid-operation discards all queued entries. Entries past count are don't-care.
// TESTING
//  T1 fill:
//   - After reset, drive icache_done=1 with data 0x00000013 every cycle; iq_ready=0.
//   - Expect 8 pushes with PCs 0x00..0x1C, then full.
//   - pc then holds 0x20, icache_addr=0x8, no further pushes.
//  T2 steady flow:
//   - With the queue full, raise iq_ready=1.
//   - Cycle 1: pop only, count 8->7.
//   - Thereafter push+pop each cycle, count stays 7.
//   - iq_pc increments by 4 and wraps the pointers correctly.
//  T3 JAL:
//   - Cache returns 0x0100006F at pc 0x10: next icache_addr=0x8 (pc 0x20).
//   - Cache returns 0xFFDFF06F at pc 0x20: next pc=0x1C.
//  T4 redirect:
//   - With 5 entries queued, assert redirect_valid with redirect_pc=0x103, icache_done=1, iq_ready=1.
//   - Next cycle: iq_valid=0, pc=0x100, icache_addr=0x40.
//   - First subsequent push has iq_pc=0x100.
//  T5 miss:
//   - Hold icache_done=0 for 3 cycles at pc 0x40.
//   - icache_addr stays 0x10 and no push occurs.
//   - Raising icache_done pushes pc 0x40 exactly once.
//  T6 rdy/reset:
//   - With rdy=0, all state is frozen even with icache_done=1 and iq_ready=1.
//   - rst mid-stream yields pc=RESET_PC and iq_valid=0 on the next cycle.

Source files
------------

// File: rtl/instruction_fetcher.sv
// Instruction fetch front end: owns the PC, reads the instruction cache every cycle and
// queues {pc, inst} pairs for the decoder, with static JAL target prediction.
module instruction_fetcher #(
    parameter int                  PC_WIDTH   = 32,
    parameter int                  ADDR_WIDTH = 17,
    parameter int                  INST_WIDTH = 32,
    parameter int                  IQ_LOG     = 3,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    output logic [ADDR_WIDTH-1:0] icache_addr,
    input  logic                  icache_done,
    input  logic [INST_WIDTH-1:0] icache_data,
    output logic                  iq_valid,
    output logic [INST_WIDTH-1:0] iq_inst,
    output logic [PC_WIDTH-1:0]   iq_pc,
    input  logic                  iq_ready,
    input  logic                  redirect_valid,
    input  logic [PC_WIDTH-1:0]   redirect_pc
);

    localparam int                  IQ_DEPTH   = 1 << IQ_LOG;
    localparam logic [6:0]          OPC_JAL    = 7'b1101111;
    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(3);

    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic [IQ_LOG-1:0]     head_q, head_d;
    logic [IQ_LOG-1:0]     tail_q, tail_d;
    logic [IQ_LOG:0]       count_q, count_d;

    logic [PC_WIDTH-1:0]   pcMem   [IQ_DEPTH];
    logic [INST_WIDTH-1:0] instMem [IQ_DEPTH];

    logic                  full;
    logic                  push;
    logic                  pop;
    logic [20:0]           jalImm;
    logic [PC_WIDTH-1:0]   nextPc;

    assign icache_addr = pc_q[ADDR_WIDTH+1:2];
    assign iq_valid    = (count_q != '0);

    // count never exceeds the depth, so its MSB alone marks a full queue
    assign full = count_q[IQ_LOG];
    assign pop  = rdy & ~redirect_valid & iq_valid & iq_ready;
    assign push = rdy & ~redirect_valid & icache_done & ~full;

    always_comb begin
        jalImm = {icache_data[31], icache_data[19:12], icache_data[20],
                  icache_data[30:21], 1'b0};
        if (icache_data[6:0] == OPC_JAL) begin
            nextPc = pc_q + {{(PC_WIDTH-21){jalImm[20]}}, jalImm};
        end else begin
            nextPc = pc_q + PC_WIDTH'(4);
        end
    end

    always_comb begin
        pc_d    = pc_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (rdy) begin
            if (redirect_valid) begin
                pc_d    = redirect_pc & ALIGN_MASK;
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
            end else begin
                if (pop) begin
                    head_d = head_q + 1'b1;
                end
                if (push) begin
                    tail_d = tail_q + 1'b1;
                    pc_d   = nextPc;
                end
                case ({push, pop})
                    2'b10:   count_d = count_q + 1'b1;
                    2'b01:   count_d = count_q - 1'b1;
                    default: count_d = count_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            pc_q    <= pc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Queue storage needs no reset: stale slots are masked off by count
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            pcMem[tail_q]   <= pc_q;
            instMem[tail_q] <= icache_data;
        end
    end

    assign iq_pc   = iq_valid ? pcMem[head_q]   : '0;
    assign iq_inst = iq_valid ? instMem[head_q] : '0;

endmodule

// File: tb/tb_instruction_fetcher.sv
// Directed bench for instruction_fetcher: stimulus queues expected {pc, inst} entries and an
// independent monitor checks every entry the decoder side actually consumes.
module tb_instruction_fetcher;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic [16:0] icache_addr;
    logic        icache_done;
    logic [31:0] icache_data;
    logic        iq_valid;
    logic [31:0] iq_inst;
    logic [31:0] iq_pc;
    logic        iq_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    entry_t expQ[$];
    int     total = 0;
    int     bad   = 0;

    instruction_fetcher dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .icache_addr    (icache_addr),
        .icache_done    (icache_done),
        .icache_data    (icache_data),
        .iq_valid       (iq_valid),
        .iq_inst        (iq_inst),
        .iq_pc          (iq_pc),
        .iq_ready       (iq_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic done, input logic [31:0] data, input logic ready,
                                 input logic redir, input logic [31:0] rpc);
        icache_done    = done;
        icache_data    = data;
        iq_ready       = ready;
        redirect_valid = redir;
        redirect_pc    = rpc;
    endtask

    task automatic expectPush(input logic [31:0] pc, input logic [31:0] inst);
        entry_t e;
        e.pc   = pc;
        e.inst = inst;
        expQ.push_back(e);
    endtask

    // Monitor: a pop happens at the coming edge, so the head must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && rdy && !redirect_valid && iq_valid && iq_ready) begin
            if (expQ.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_pop: got pc 0x%08h expected no entry", iq_pc);
            end else begin
                entry_t e;
                e = expQ.pop_front();
                checkOutput("pop_pc", iq_pc, e.pc);
                checkOutput("pop_inst", iq_inst, e.inst);
            end
        end
    end

    initial begin
        rst = 1'b1;
        rdy = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        tick();
        checkOutput("reset_addr", {15'd0, icache_addr}, 32'h0);
        checkOutput("reset_valid", {31'd0, iq_valid}, 32'h0);
        checkOutput("reset_pc", iq_pc, 32'h0);
        checkOutput("reset_inst", iq_inst, 32'h0);

        // T1: fill the queue with eight sequential hits
        rst = 1'b0;
        applyStimulus(1'b1, 32'h00000013, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 8; i++) begin
            checkOutput("fill_addr", {15'd0, icache_addr}, 32'(i));
            expectPush(32'(i * 4), 32'h00000013);
            tick();
        end
        checkOutput("full_valid", {31'd0, iq_valid}, 32'h1);
        checkOutput("full_head_pc", iq_pc, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("full_hold_addr", {15'd0, icache_addr}, 32'h8);
        end

        // T2: steady flow, first edge pops only, then push+pop each cycle
        applyStimulus(1'b1, 32'h00000013, 1'b1, 1'b0, 32'h0);
        for (int k = 1; k <= 12; k++) begin
            if (k >= 2) expectPush(32'h20 + 32'((k - 2) * 4), 32'h00000013);
            tick();
            checkOutput("flow_head_pc", iq_pc, 32'(k * 4));
            checkOutput("flow_addr", {15'd0, icache_addr}, 32'(8 + k - 1));
        end
        applyStimulus(1'b0, 32'h00000013, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 7; i++) tick();
        checkOutput("drain_valid", {31'd0, iq_valid}, 32'h0);

        // T3: JAL prediction forward and backward
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h10);
        tick();
        expQ.delete();
        checkOutput("redir10_addr", {15'd0, icache_addr}, 32'h4);
        applyStimulus(1'b1, 32'h0100006F, 1'b0, 1'b0, 32'h0);
        expectPush(32'h10, 32'h0100006F);
        tick();
        checkOutput("jal_fwd_addr", {15'd0, icache_addr}, 32'h8);
        applyStimulus(1'b1, 32'hFFDFF06F, 1'b0, 1'b0, 32'h0);
        expectPush(32'h20, 32'hFFDFF06F);
        tick();
        checkOutput("jal_back_addr", {15'd0, icache_addr}, 32'h7);
        checkOutput("jal_head_pc", iq_pc, 32'h10);
        checkOutput("jal_head_inst", iq_inst, 32'h0100006F);

        // T4: three more entries to reach five, then redirect with everything else active
        applyStimulus(1'b1, 32'h00000013, 1'b0, 1'b0, 32'h0);
        expectPush(32'h1C, 32'h00000013);
        tick();
        expectPush(32'h20, 32'h00000013);
        tick();
        expectPush(32'h24, 32'h00000013);
        tick();
        applyStimulus(1'b1, 32'h00000013, 1'b1, 1'b1, 32'h103);
        tick();
        expQ.delete();
        checkOutput("redir_valid", {31'd0, iq_valid}, 32'h0);
        checkOutput("redir_addr", {15'd0, icache_addr}, 32'h40);
        applyStimulus(1'b1, 32'h00000013, 1'b0, 1'b0, 32'h0);
        expectPush(32'h100, 32'h00000013);
        tick();
        checkOutput("redir_push_valid", {31'd0, iq_valid}, 32'h1);
        checkOutput("redir_push_pc", iq_pc, 32'h100);

        // T5: cache miss holds the PC
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h40);
        tick();
        expQ.delete();
        applyStimulus(1'b0, 32'h00000013, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("miss_addr", {15'd0, icache_addr}, 32'h10);
            checkOutput("miss_valid", {31'd0, iq_valid}, 32'h0);
        end
        applyStimulus(1'b1, 32'h00000013, 1'b0, 1'b0, 32'h0);
        expectPush(32'h40, 32'h00000013);
        tick();
        applyStimulus(1'b0, 32'h00000013, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("hit_valid", {31'd0, iq_valid}, 32'h1);
        checkOutput("hit_addr", {15'd0, icache_addr}, 32'h11);
        applyStimulus(1'b0, 32'h00000013, 1'b1, 1'b0, 32'h0);
        tick();
        checkOutput("hit_once_valid", {31'd0, iq_valid}, 32'h0);

        // T6: rdy freeze, then reset mid-stream
        applyStimulus(1'b1, 32'h00000013, 1'b0, 1'b0, 32'h0);
        expectPush(32'h44, 32'h00000013);
        tick();
        expectPush(32'h48, 32'h00000013);
        tick();
        rdy = 1'b0;
        applyStimulus(1'b1, 32'h00000013, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("frz_addr", {15'd0, icache_addr}, 32'h13);
            checkOutput("frz_head_pc", iq_pc, 32'h44);
            checkOutput("frz_valid", {31'd0, iq_valid}, 32'h1);
        end
        rdy = 1'b1;
        expectPush(32'h4C, 32'h00000013);
        tick();
        checkOutput("unfrz_head_pc", iq_pc, 32'h48);
        checkOutput("unfrz_addr", {15'd0, icache_addr}, 32'h14);
        rst = 1'b1;
        tick();
        expQ.delete();
        checkOutput("rst_mid_addr", {15'd0, icache_addr}, 32'h0);
        checkOutput("rst_mid_valid", {31'd0, iq_valid}, 32'h0);
        rst = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("post_rst_valid", {31'd0, iq_valid}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
